// File: rtl/channel_pwm_voice.sv
// Channel voice: NCO pulse wave scaled by envelope into a PWM bit.
// Top and compare values update only at period boundaries.
module channel_pwm_voice #(
   parameter int         DUTY      = 4,
   parameter logic [7:0] RESET_TOP = 8'hff
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_top,
   input  logic        i_top_valid,
   input  logic [31:0] i_phase_delta,
   input  logic [8:0]  i_envelope,
   output logic        o_pwm,
   output logic        o_period_start,
   output logic [8:0]  o_sample
);

   localparam logic [3:0] DUTY_L = 4'(DUTY);

   logic [31:0] r_phase;
   logic [7:0]  r_cnt;
   logic [7:0]  r_top;
   logic [7:0]  r_top_pend;
   logic        pend_flag;
   logic [8:0]  r_cmp;

   logic        terminal;
   logic        wave;
   logic [8:0]  sample;

   assign terminal = (r_cnt == r_top);
   assign wave     = ({1'b0, r_phase[31:29]} < DUTY_L);
   assign sample   = wave ? i_envelope : 9'd0;
   assign o_sample = r_cmp;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_phase        <= '0;
         r_cnt          <= '0;
         r_top          <= RESET_TOP;
         r_top_pend     <= '0;
         pend_flag      <= 1'b0;
         r_cmp          <= '0;
         o_pwm          <= 1'b0;
         o_period_start <= 1'b0;
      end else begin
         r_phase        <= r_phase + i_phase_delta;
         // 9-bit compare so a compare above top saturates high
         o_pwm          <= ({1'b0, r_cnt} < r_cmp);
         o_period_start <= terminal;
         if (terminal) begin
            r_cnt <= '0;
            r_cmp <= sample;
            if (i_top_valid) begin
               r_top     <= i_top;
               pend_flag <= 1'b0;
            end else if (pend_flag) begin
               r_top     <= r_top_pend;
               pend_flag <= 1'b0;
            end
         end else begin
            r_cnt <= r_cnt + 8'd1;
            if (i_top_valid) begin
               r_top_pend <= i_top;
               pend_flag  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_channel_pwm_voice.sv
// Randomized bench for channel_pwm_voice against a period-level model.
module tb_channel_pwm_voice;

   localparam int DUTY = 4;
   localparam int RTOP = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  top;
   logic        tv;
   logic [31:0] dl;
   logic [8:0]  env;
   logic        pwm;
   logic        ps;
   logic [8:0]  smp;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   channel_pwm_voice #(
      .DUTY      (DUTY),
      .RESET_TOP (8'(RTOP))
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_top          (top),
      .i_top_valid    (tv),
      .i_phase_delta  (dl),
      .i_envelope     (env),
      .o_pwm          (pwm),
      .o_period_start (ps),
      .o_sample       (smp)
   );

   // model: position inside the current period and its length in clocks
   bit [31:0] m_phase;
   int        m_pos;
   int        m_len;
   int        m_next;
   int        m_cmp;
   int        m_pwm;
   int        m_ps;
   bit        m_ok = 1'b0;

   task automatic check(string tag, int got, int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit last;
      if (rst) begin
         m_phase = 0;
         m_pos   = 0;
         m_len   = RTOP + 1;
         m_next  = -1;
         m_cmp   = 0;
         m_pwm   = 0;
         m_ps    = 0;
         m_ok    = 1'b1;
      end else begin
         last  = (m_pos == m_len - 1);
         m_pwm = (m_pos < m_cmp) ? 1 : 0;
         m_ps  = last ? 1 : 0;
         if (last) begin
            m_cmp = ((m_phase >> 29) < DUTY) ? int'(env) : 0;
            if (tv) m_len = int'(top) + 1;
            else if (m_next >= 0) m_len = m_next;
            m_next = -1;
            m_pos  = 0;
         end else begin
            m_pos++;
            if (tv) m_next = int'(top) + 1;
         end
         m_phase = m_phase + dl;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      if (m_ok) begin
         check("pwm", int'(pwm), m_pwm);
         check("period_start", int'(ps), m_ps);
         check("sample", int'(smp), m_cmp);
      end
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_to_pos(int p);
      int n = 0;
      while (m_pos != p && n < 600) begin
         tick();
         n++;
      end
      check("pos_reach", m_pos, p);
   endtask

   task automatic set_top(logic [7:0] t);
      top = t;
      tv  = 1'b1;
      tick();
      tv  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      top = 8'($urandom);
      tv  = 1'($urandom);
      dl  = $urandom;
      env = 9'($urandom);
      ticks(3);
      rst = 1'b0;
      tv  = 1'b0;
      ticks(300);

      // static duty
      dl  = 0;
      env = 9'd2;
      set_top(8'd3);
      ticks(300);

      // saturation both ways
      env = 9'h1ff;
      ticks(20);
      env = 9'd0;
      ticks(20);

      // NCO toggle at top=0 across several phase wraps
      env = 9'd1;
      dl  = 32'h2000_0000;
      set_top(8'd0);
      ticks(80);

      // top handshake: two writes mid-period, then bypass on terminal
      dl  = 0;
      env = 9'd5;
      set_top(8'd7);
      ticks(20);
      run_to_pos(7);
      tick();
      run_to_pos(3);
      top = 8'd1; tv = 1'b1; tick(); tv = 1'b0;
      run_to_pos(5);
      top = 8'd2; tv = 1'b1; tick(); tv = 1'b0;
      ticks(12);
      run_to_pos(2);
      top = 8'd5; tv = 1'b1; tick(); tv = 1'b0;
      ticks(20);

      // reset mid 256-clock period
      dl = 32'h0123_4567;
      env = 9'd200;
      set_top(8'd255);
      ticks(10);
      run_to_pos(100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ticks(520);

      // randomized segments
      for (int seg = 0; seg < 40; seg++) begin
         top = 8'($urandom_range(0, 9));
         tv  = 1'b1;
         case ($urandom_range(0, 3))
            0: env = 9'd0;
            1: env = 9'h1ff;
            2: env = 9'($urandom_range(0, 12));
            default: env = 9'($urandom);
         endcase
         dl = $urandom_range(0, 1) ? $urandom
                                   : (32'($urandom_range(0, 7)) << 27);
         for (int c = 0; c < 150; c++) begin
            tick();
            tv  = ($urandom_range(0, 9) == 0);
            if (tv) top = 8'($urandom_range(0, 9));
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) env = 9'($urandom_range(0, 12));
         end
         rst = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
